// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register, IF/ID pipeline register and run/halt fetch control.
module if_fetch_unit #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [7:0]  im_addr,
  input  logic [31:0] im_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
);
  typedef enum logic {RUN, HALT} state_t;
  state_t      state, state_n;
  logic [31:0] pc_n, instr_n, pc4_n, pc_inc;
  logic        valid_n;
  assign pc_inc  = pc + 32'd4;
  assign im_addr = pc[9:2];
  assign halted  = state == HALT;
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= RUN;
      pc          <= PC_RESET;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_id_instr <= instr_n;
      if_id_pc4   <= pc4_n;
      if_id_valid <= valid_n;
    end
  end
  // A halt word is still passed down the pipe so it can retire; only the PC freezes.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = if_id_instr;
    pc4_n   = if_id_pc4;
    valid_n = if_id_valid;
    if (redirect) begin
      pc_n    = redirect_pc & ~32'd3;
      instr_n = '0;
      pc4_n   = '0;
      valid_n = 1'b0;
      state_n = RUN;
    end else if (!stall && state == HALT) begin
      instr_n = '0;
      pc4_n   = '0;
      valid_n = 1'b0;
    end else if (!stall) begin
      instr_n = im_instr;
      pc4_n   = pc_inc;
      valid_n = 1'b1;
      if (im_instr[31:26] == HALT_OPCODE) state_n = HALT;
      else pc_n = pc_inc;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed plus random checks of if_fetch_unit against a behavioural model.
module tb_if_fetch_unit;
  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  im_addr;
  logic [31:0] im_instr;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc, if_id_instr, if_id_pc4;
  logic        if_id_valid, halted;
  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_instr, m_pc4, w;
  logic        m_valid, m_halted;

  if_fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .im_addr(im_addr), .im_instr(im_instr),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .halted(halted)
  );

  assign im_instr = mem[im_addr];
  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_pc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0; m_halted <= 1'b0;
    end else if (redirect) begin
      m_pc <= {redirect_pc[31:2], 2'b00};
      m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0; m_halted <= 1'b0;
    end else if (!stall) begin
      if (m_halted) begin
        m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
      end else begin
        w = mem[(m_pc / 4) % 256];
        m_instr <= w;
        m_pc4 <= m_pc + 4;
        m_valid <= 1'b1;
        if (w[31:26] == 6'h3F) m_halted <= 1'b1;
        else m_pc <= m_pc + 4;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic s, input logic r, input logic [31:0] rp);
    #1;
    stall = s; redirect = r; redirect_pc = rp;
    @(negedge CLK);
  endtask

  initial begin
    mem[0] = 32'h2001_0001; mem[1] = 32'h2002_0002; mem[2] = 32'h0022_1820; mem[3] = 32'h0;
    for (int i = 4; i < 256; i++) mem[i] = {6'h08, 26'(i * 7 + 3)};
    mem[5] = 32'hFC00_0000;
    fork
      forever begin
        @(negedge CLK);
        chk("model_pc", pc, m_pc);
        chk("model_im_addr", {24'h0, im_addr}, {24'h0, m_pc[9:2]});
        chk("model_instr", if_id_instr, m_instr);
        chk("model_pc4", if_id_pc4, m_pc4);
        chk("model_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        chk("model_halted", {31'h0, halted}, {31'h0, m_halted});
      end
    join_none
    @(negedge CLK);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    #1 Reset = 1'b0;
    @(negedge CLK);
    chk("seq0_instr", if_id_instr, 32'h2001_0001);
    chk("seq0_pc4", if_id_pc4, 32'd4);
    chk("seq0_valid", {31'h0, if_id_valid}, 32'h1);
    chk("seq0_addr", {24'h0, im_addr}, 32'd1);
    cyc(0, 0, 0);
    chk("seq1_instr", if_id_instr, 32'h2002_0002);
    chk("seq1_pc4", if_id_pc4, 32'd8);
    cyc(0, 0, 0);
    chk("seq2_instr", if_id_instr, 32'h0022_1820);
    chk("seq2_pc4", if_id_pc4, 32'd12);
    cyc(0, 0, 0);
    chk("seq3_instr", if_id_instr, 32'h0);
    chk("seq3_pc4", if_id_pc4, 32'd16);
    chk("seq3_addr", {24'h0, im_addr}, 32'd4);
    cyc(0, 1, 32'h4);
    cyc(0, 0, 0);
    chk("pre_stall_pc", pc, 32'd8);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      chk("stall_pc", pc, 32'd8);
      chk("stall_instr", if_id_instr, 32'h2002_0002);
      chk("stall_pc4", if_id_pc4, 32'd8);
      chk("stall_valid", {31'h0, if_id_valid}, 32'h1);
    end
    cyc(0, 0, 0);
    chk("unstall_pc", pc, 32'd12);
    cyc(0, 1, 32'h10);
    chk("redir_pc10", pc, 32'h10);
    cyc(1, 1, 32'h41);
    chk("redir_pc", pc, 32'h40);
    chk("redir_addr", {24'h0, im_addr}, 32'h10);
    chk("redir_valid", {31'h0, if_id_valid}, 32'h0);
    chk("redir_instr", if_id_instr, 32'h0);
    cyc(0, 0, 0);
    chk("post_redir_instr", if_id_instr, mem[16]);
    chk("post_redir_pc4", if_id_pc4, 32'h44);
    cyc(0, 1, 32'h10);
    cyc(0, 0, 0);
    chk("pre_halt_pc", pc, 32'h14);
    cyc(0, 0, 0);
    chk("halt_instr", if_id_instr, 32'hFC00_0000);
    chk("halt_valid", {31'h0, if_id_valid}, 32'h1);
    chk("halt_halted", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      chk("halt_pc", pc, 32'h14);
      chk("halt_bubble_valid", {31'h0, if_id_valid}, 32'h0);
      chk("halt_bubble_instr", if_id_instr, 32'h0);
    end
    cyc(0, 1, 32'h30);
    chk("unhalt_halted", {31'h0, halted}, 32'h0);
    chk("unhalt_pc", pc, 32'h30);
    cyc(0, 0, 0);
    chk("unhalt_instr", if_id_instr, mem[12]);
    cyc(0, 1, 32'h28);
    #1 redirect = 1'b0;
    Reset = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_valid", {31'h0, if_id_valid}, 32'h0);
    chk("async_halted", {31'h0, halted}, 32'h0);
    #1 Reset = 1'b0;
    @(negedge CLK);
    chk("refetch_instr", if_id_instr, 32'h2001_0001);
    chk("refetch_pc", pc, 32'h4);
    cyc(0, 1, 32'hFFFF_FFFC);
    chk("wrap_addr", {24'h0, im_addr}, 32'hFF);
    cyc(0, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_instr", if_id_instr, mem[255]);
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? {6'h3F, 26'($urandom)} : {6'($urandom_range(0, 62)), 26'($urandom)};
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        #1 Reset = 1'b1;
        #2 Reset = 1'b0;
        @(negedge CLK);
      end else begin
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023)));
      end
      if ($urandom_range(0, 19) == 0) mem[$urandom_range(0, 255)] = $urandom;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the pipelined CPU; drives the word address into the instruction memory and reads its combinational instruction output.
- Holds the PC and the IF/ID pipeline register.
- Takes stall from hazard detection and redirect from branch/jump resolution.
- Freezes fetch on the halt opcode until a redirect or reset.

Parameters:
- PC_RESET, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- HALT_OPCODE, 6'b111111: instr[31:26] value that stops fetch.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- im_addr  out  8  word address to instruction memory; always pc[9:2], combinational.
- im_instr  in  32  instruction returned by the memory for im_addr, same cycle.
- stall  in  1  hold PC and IF/ID contents.
- redirect  in  1  taken branch/jump; overrides the sequential PC.
- redirect_pc  in  32  byte address of the redirect target.
- pc  out  32  current fetch PC (byte address).
- if_id_instr  out  32  IF/ID latched instruction.
- if_id_pc4  out  32  IF/ID latched PC+4.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- halted  out  1  high while in HALT state.

Behaviour:
- Reset (Reset=1, async, any state): pc=PC_RESET, if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0, state=RUN. Holds while Reset is high. First fetch is on the first rising edge after deassertion.
- Latency: the instruction at pc appears on if_id_* one edge later. im_addr follows pc with no cycle delay.
- States:
  - RUN: fetching.
  - HALT: PC frozen, bubbles issued.
- Per-edge priority: Reset > redirect > stall > halt detect > normal.
- redirect=1 (RUN or HALT):
  - pc <= {redirect_pc[31:2],2'b00}.
  - IF/ID flushed: instr=0, pc4=0, valid=0.
  - state <= RUN, halted <= 0.
  - stall in the same cycle is ignored.
- stall=1, redirect=0: pc, if_id_*, and state all unchanged. This applies in both states.
- RUN, no stall/redirect, im_instr[31:26] != HALT_OPCODE:
  - pc <= pc+4, modulo 2^32. Wrap 32'hFFFF_FFFC -> 0.
  - if_id_instr <= im_instr, if_id_pc4 <= pc+4, if_id_valid <= 1.
- RUN, no stall/redirect, im_instr[31:26] == HALT_OPCODE:
  - Halt instruction is latched into IF/ID with valid=1 so it propagates to retire.
  - pc unchanged.
  - state <= HALT, halted <= 1 (visible after the same edge).
- HALT, no stall/redirect:
  - pc unchanged.
  - if_id_instr <= 0, if_id_pc4 <= 0, if_id_valid <= 0. Bubbles continue every cycle.
- Leaving HALT: a redirect exits (the halt was fetched speculatively past an older branch). Otherwise only Reset exits.
- Address aliasing: im_addr uses pc[9:2] only. PC beyond 1 KiB aliases into the 256-word memory, with no error flag.
- Misaligned redirect_pc: low two bits are silently dropped.
- Reset asserted mid-stall or mid-halt: immediate return to reset values, independent of CLK.
- No X on any output after reset. Unknown im_instr is latched as-is (memory's responsibility).

Test Plan:
- Reset, IM words 0..3 = 0x20010001, 0x20020002, 0x00221820, 0x00000000, 4 edges -> im_addr 0,1,2,3. if_id_instr follows each word one edge later. if_id_pc4 = 4,8,12,16. valid=1 from the first edge.
- Running at pc=8, stall=1 for 3 edges -> pc stays 8, if_id_instr/pc4/valid unchanged. After release, pc=12 on the next edge.
- At pc=0x10, redirect=1, redirect_pc=0x41 with stall=1 the same edge -> pc=0x40, im_addr=0x10, if_id_valid=0, if_id_instr=0. Next edge latches word 0x10 with pc4=0x44.
- IM word 5 = 0xFC000000, fetch reaches pc=0x14 -> after the edge, if_id_instr=0xFC000000, valid=1, halted=1. Next 5 edges: pc=0x14, valid=0, instr=0. Then redirect to 0x30 -> halted=0, fetch resumes at word 12.
- Mid-run at pc=0x28, assert Reset between edges for half a cycle -> pc=0, if_id_valid=0, halted=0 immediately, without a clock edge. After release, refetch word 0.
- Redirect to 0xFFFF_FFFC, no stall -> im_addr=0xFF. Next edge pc=0x0000_0000, if_id_pc4=0x0000_0000 (wrap).
